if_stage_unit: RTL
==================

IF_STAGE_UNIT -- requirements
Module: if_stage_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000: instruction word inserted as a bubble.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 PC_LE  input  1  PC load enable from hazard unit; 0 means load-use stall.
REQ-006 IFID_LE  input  1  IF/ID register load enable from hazard unit.
REQ-007 branch_taken  input  1  redirect request from the branch-resolving stage.
REQ-008 branch_target  input  32  redirect address.
REQ-009 imem_addr  output  32  fetch address, equal to the current PC (combinational).
REQ-010 imem_req  output  1  fetch request; 0 while reset is asserted, else 1.
REQ-011 imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-012 imem_ready  input  1  instruction memory has returned data for imem_addr this cycle.
REQ-013 ifid_instr  output  32  registered instruction to the decode stage.
REQ-014 ifid_pc  output  32  registered PC of ifid_instr.
REQ-015 ifid_valid  output  1  ifid_instr is a real instruction; 0 marks a bubble.
REQ-016 fetch_state  output  2  current FSM state (encoding per REQ-020).
REQ-017 stall_count  output  16  saturating count of hazard-stall cycles.
REQ-018 miss_count  output  16  saturating count of memory-wait cycles.

Function
REQ-019 Per-cycle priority: reset > branch_taken > PC_LE=0 > imem_ready=0 > normal advance.
REQ-020 FSM states: BOOT=2'b00, RUN=2'b01, HAZ=2'b10, MWAIT=2'b11.
REQ-021 BOOT lasts exactly one cycle after reset deassertion; PC holds and IF/ID is loaded with a bubble; the next state is RUN.
REQ-022 In RUN, HAZ or MWAIT, the next state is HAZ if PC_LE=0 and branch_taken=0, else MWAIT if imem_ready=0 and branch_taken=0, else RUN.
REQ-023 Normal advance: PC <= PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0); if IFID_LE=1, IF/ID <= {imem_rdata, PC, valid=1}.
REQ-024 branch_taken=1: PC <= {branch_target[31:2], 2'b00}; IF/ID <= {NOP_INSTR, branch_target aligned, valid=0}, regardless of IFID_LE, PC_LE or imem_ready.
REQ-025 PC_LE=0 (no branch): PC holds; IF/ID holds if IFID_LE=0, else loads a bubble; stall_count increments.
REQ-026 imem_ready=0 with PC_LE=1 (no branch): PC holds; IF/ID loads a bubble if IFID_LE=1, else holds; miss_count increments.
REQ-027 PC_LE=1 with IFID_LE=0: PC advances and IF/ID holds (defined behaviour, not an error).
REQ-028 Counters saturate at 16'hFFFF and never wrap.
REQ-029 Bubble encoding: ifid_instr=NOP_INSTR, ifid_valid=0.

Reset
REQ-030 Reset values while reset=1 and on the first cycle after it: PC=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc=RESET_PC, ifid_valid=0, fetch_state=BOOT, stall_count=0, miss_count=0.
REQ-031 Reset asserted mid-stall or mid-wait overrides all other inputs on that edge.

Structure
REQ-032 State encodings, NOP_INSTR default and the PC increment constant (4) SHALL reside in the shared pipeline package.
REQ-033 One sub-module, sat_counter16, SHALL be instantiated twice for stall_count and miss_count.

Verification
REQ-034 Reset, then imem_ready=1 for 4 cycles -> ifid_pc sequence 0,0(BOOT bubble),0,4,8 with ifid_valid 0,0,1,1,1.
REQ-035 PC_LE=0, IFID_LE=0 for 2 cycles at PC=0x10 -> PC stays 0x10, IF/ID unchanged, stall_count=2, fetch_state=HAZ.
REQ-036 imem_ready=0 for 3 cycles at PC=0x20 -> PC stays 0x20, ifid_valid=0, miss_count=3; on the ready cycle ifid_pc=0x20.
REQ-037 branch_taken=1 with target 0x103 while PC_LE=0 -> next PC=0x100, ifid_valid=0, stall_count unchanged.
REQ-038 RESET_PC=32'hFFFF_FFFC, one normal advance -> PC=0, ifid_pc=32'hFFFF_FFFC.
REQ-039 Force stall_count to 16'hFFFF via a long PC_LE=0 run -> remains 16'hFFFF.

Source files
------------

// File: rtl/if_stage_unit_pkg.sv
// ---------------------------------------------------------------------------
// if_stage_unit_pkg
// Shared pipeline definitions for the instruction-fetch stage: fetch FSM
// state encoding, the default bubble instruction, the PC increment, the
// IF/ID register layout and the counter saturation limit.
// ---------------------------------------------------------------------------
package if_stage_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_HAZ   = 2'b10,
    ST_MWAIT = 2'b11
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INCREMENT      = 32'd4;
  localparam logic [15:0] CNT_MAX           = 16'hFFFF;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } ifid_t;

  // Force an address onto a 4-byte instruction boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// ---------------------------------------------------------------------------
// sat_counter16
// 16-bit event counter that sticks at its maximum instead of wrapping.
// Ports:
//   clk      - clock, rising edge
//   reset_i  - synchronous active-high clear
//   inc_i    - count one event this cycle
//   count_o  - current count
// ---------------------------------------------------------------------------
module sat_counter16
  import if_stage_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset_i,
  input  logic        inc_i,
  output logic [15:0] count_o
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    count_d = count_q;
    if (inc_i && (count_q != CNT_MAX)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/if_stage_unit.sv
// ---------------------------------------------------------------------------
// if_stage_unit
// Instruction-fetch stage: owns the PC, issues fetches, and fills the IF/ID
// register with fetched instructions or bubbles. Per-cycle priority is
// reset > branch redirect > load-use stall > memory wait > normal advance.
// Ports:
//   clk, reset                 - clock and synchronous active-high reset
//   PC_LE, IFID_LE             - load enables from the hazard unit
//   branch_taken/branch_target - redirect from the branch-resolving stage
//   imem_addr/imem_req         - fetch address (current PC) and request
//   imem_rdata/imem_ready      - returned instruction and its valid flag
//   ifid_instr/ifid_pc/ifid_valid - IF/ID register toward decode
//   fetch_state                - current FSM state
//   stall_count/miss_count     - saturating hazard-stall / memory-wait counts
// ---------------------------------------------------------------------------
module if_stage_unit
  import if_stage_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_LE,
  input  logic        IFID_LE,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic        ifid_valid,
  output logic [1:0]  fetch_state,
  output logic [15:0] stall_count,
  output logic [15:0] miss_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  ifid_t        ifid_q, ifid_d;
  logic         stall_inc;
  logic         miss_inc;
  logic [31:0]  target_aligned;

  assign target_aligned = align_word(branch_target);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ifid_d    = ifid_q;
    stall_inc = 1'b0;
    miss_inc  = 1'b0;

    if (state_q == ST_BOOT) begin
      // Single settling cycle after reset: PC holds, decode sees a bubble.
      ifid_d  = '{instr: NOP_INSTR, pc: pc_q, valid: 1'b0};
      state_d = ST_RUN;
    end else if (branch_taken) begin
      // Redirect wins over every hazard; the wrong-path slot becomes a bubble.
      pc_d    = target_aligned;
      ifid_d  = '{instr: NOP_INSTR, pc: target_aligned, valid: 1'b0};
      state_d = ST_RUN;
    end else if (!PC_LE) begin
      if (IFID_LE) begin
        ifid_d = '{instr: NOP_INSTR, pc: pc_q, valid: 1'b0};
      end
      stall_inc = 1'b1;
      state_d   = ST_HAZ;
    end else if (!imem_ready) begin
      if (IFID_LE) begin
        ifid_d = '{instr: NOP_INSTR, pc: pc_q, valid: 1'b0};
      end
      miss_inc = 1'b1;
      state_d  = ST_MWAIT;
    end else begin
      // Unsigned add wraps naturally at 2^32.
      pc_d = pc_q + PC_INCREMENT;
      if (IFID_LE) begin
        ifid_d = '{instr: imem_rdata, pc: pc_q, valid: 1'b1};
      end
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      ifid_q  <= '{instr: NOP_INSTR, pc: RESET_PC, valid: 1'b0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
    end
  end

  sat_counter16 u_stall_cnt (
    .clk     (clk),
    .reset_i (reset),
    .inc_i   (stall_inc),
    .count_o (stall_count)
  );

  sat_counter16 u_miss_cnt (
    .clk     (clk),
    .reset_i (reset),
    .inc_i   (miss_inc),
    .count_o (miss_count)
  );

  assign imem_addr   = pc_q;
  assign imem_req    = ~reset;
  assign ifid_instr  = ifid_q.instr;
  assign ifid_pc     = ifid_q.pc;
  assign ifid_valid  = ifid_q.valid;
  assign fetch_state = state_q;

endmodule
